// File: rtl/core_sum_link.sv
// rtl/core_sum_link.sv - registered dual-core partial-sum link, one show-ahead FIFO per direction

module core_sum_link_dir #(
  parameter int DW     = 24,
  parameter int DEPTH  = 4,
  parameter int CNT_BW = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              link_en_i,
  input  logic [DW-1:0]     prod_data_i,
  input  logic              prod_vld_i,
  output logic              prod_rd_o,
  output logic [DW-1:0]     cons_data_o,
  output logic              cons_vld_o,
  input  logic              cons_rd_i,
  output logic [CNT_BW-1:0] xfer_cnt_o,
  output logic              empty_rd_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [DW-1:0]     mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic [CNT_BW-1:0] xfer_q, xfer_d;
  logic              wr, rd;

  // Producer pop depends only on registered state, never on the consumer's pop.
  assign wr          = ~reset & link_en_i & prod_vld_i & (count_q != FULL);
  assign rd          = cons_rd_i & (count_q != '0);
  assign prod_rd_o   = wr;
  assign cons_data_o = mem_q[rd_ptr_q];
  assign cons_vld_o  = ~reset & (count_q != '0);
  assign empty_rd_o  = cons_rd_i & (count_q == '0);
  assign xfer_cnt_o  = xfer_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    xfer_d   = xfer_q;
    if (wr) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      xfer_d   = xfer_q + CNT_BW'(1);
    end
    if (rd) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({wr, rd})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      xfer_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      xfer_q   <= xfer_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) begin
      mem_q[wr_ptr_q] <= prod_data_i;
    end
  end
endmodule

module core_sum_link #(
  parameter int bw_psum = 20,
  parameter int depth   = 4,
  parameter int cnt_bw  = 8,
  parameter int DW      = bw_psum + 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              link_en,
  input  logic [DW-1:0]     a_sum_out,
  input  logic              a_sum_out_vld,
  output logic              a_fifo_ext_rd,
  output logic [DW-1:0]     a_sum_in,
  output logic              a_sum_rd_vld,
  input  logic              a_link_rd,
  input  logic [DW-1:0]     b_sum_out,
  input  logic              b_sum_out_vld,
  output logic              b_fifo_ext_rd,
  output logic [DW-1:0]     b_sum_in,
  output logic              b_sum_rd_vld,
  input  logic              b_link_rd,
  output logic [cnt_bw-1:0] a2b_cnt,
  output logic [cnt_bw-1:0] b2a_cnt,
  output logic              underflow
);
  logic a2b_empty_rd, b2a_empty_rd;
  logic underflow_q, underflow_d;

  core_sum_link_dir #(.DW(DW), .DEPTH(depth), .CNT_BW(cnt_bw)) u_a2b (
    .clk         (clk),
    .reset       (reset),
    .link_en_i   (link_en),
    .prod_data_i (a_sum_out),
    .prod_vld_i  (a_sum_out_vld),
    .prod_rd_o   (a_fifo_ext_rd),
    .cons_data_o (b_sum_in),
    .cons_vld_o  (b_sum_rd_vld),
    .cons_rd_i   (b_link_rd),
    .xfer_cnt_o  (a2b_cnt),
    .empty_rd_o  (a2b_empty_rd)
  );

  core_sum_link_dir #(.DW(DW), .DEPTH(depth), .CNT_BW(cnt_bw)) u_b2a (
    .clk         (clk),
    .reset       (reset),
    .link_en_i   (link_en),
    .prod_data_i (b_sum_out),
    .prod_vld_i  (b_sum_out_vld),
    .prod_rd_o   (b_fifo_ext_rd),
    .cons_data_o (a_sum_in),
    .cons_vld_o  (a_sum_rd_vld),
    .cons_rd_i   (a_link_rd),
    .xfer_cnt_o  (b2a_cnt),
    .empty_rd_o  (b2a_empty_rd)
  );

  assign underflow_d = underflow_q | a2b_empty_rd | b2a_empty_rd;
  assign underflow   = underflow_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      underflow_q <= 1'b0;
    end else begin
      underflow_q <= underflow_d;
    end
  end
endmodule
